// File: rtl/atm_session_ctrl.sv
// Per-session ATM controller: card load, PIN check with retry limit,
// balance/withdraw/deposit menu on a working balance, commit and eject.
module atm_session_ctrl #(
    parameter int PASS_WIDTH     = 16,
    parameter int BLNC_WIDTH     = 20,
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  card_in,
    input  logic                  pass_flag,
    input  logic [PASS_WIDTH-1:0] password,
    input  logic [BLNC_WIDTH-1:0] balance,
    input  logic                  pin_valid,
    input  logic [PASS_WIDTH-1:0] pin_entry,
    input  logic                  op_valid,
    input  logic [1:0]            op_sel,
    input  logic [BLNC_WIDTH-1:0] amount,
    output logic                  operation_done,
    output logic                  card_out,
    output logic [BLNC_WIDTH-1:0] update_balance,
    output logic [BLNC_WIDTH-1:0] disp_balance,
    output logic                  dispense_valid,
    output logic [BLNC_WIDTH-1:0] dispense_amount,
    output logic                  pin_error,
    output logic                  insufficient,
    output logic                  card_captured,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, PIN_WAIT, MENU, COMMIT, EJECT, CAPTURE
    } state_t;

    state_t state, next_state;

    logic [TW-1:0]         timer;
    logic [CW-1:0]         tries;
    logic [BLNC_WIDTH-1:0] wbal;
    logic [BLNC_WIDTH:0]   dep_sum;
    logic                  timeout;
    logic                  load_ok;
    logic                  pin_bad;
    logic                  op_show;
    logic                  op_wd;
    logic                  op_dep;
    logic                  op_reject;
    logic                  clear_timer;

    // Deposit is evaluated one bit wider so a carry flags overflow.
    assign dep_sum = {1'b0, wbal} + {1'b0, amount};
    assign timeout = (timer == TW'(TIMEOUT_CYCLES));

    always_comb begin
        next_state  = state;
        load_ok     = 1'b0;
        pin_bad     = 1'b0;
        op_show     = 1'b0;
        op_wd       = 1'b0;
        op_dep      = 1'b0;
        op_reject   = 1'b0;
        clear_timer = 1'b0;
        case (state)
            IDLE: begin
                if (card_in) next_state = LOAD;
            end
            LOAD: begin
                if (!pass_flag) begin
                    next_state = EJECT;
                end else begin
                    load_ok    = 1'b1;
                    next_state = PIN_WAIT;
                end
            end
            PIN_WAIT: begin
                // Card removal outranks any strobe arriving in the same cycle.
                if (!card_in) begin
                    next_state = IDLE;
                end else if (pin_valid) begin
                    if (pin_entry == password) begin
                        next_state = MENU;
                    end else begin
                        pin_bad = 1'b1;
                        if (tries <= CW'(1)) next_state = CAPTURE;
                    end
                end else if (timeout) begin
                    next_state = EJECT;
                end
            end
            MENU: begin
                if (!card_in) begin
                    next_state = COMMIT;
                end else if (op_valid) begin
                    clear_timer = 1'b1;
                    case (op_sel)
                        2'b00: op_show = 1'b1;
                        2'b01: begin
                            if (amount > wbal) op_reject = 1'b1;
                            else               op_wd     = 1'b1;
                        end
                        2'b10: begin
                            if (dep_sum[BLNC_WIDTH]) op_reject = 1'b1;
                            else                     op_dep    = 1'b1;
                        end
                        default: next_state = COMMIT;
                    endcase
                end else if (timeout) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: next_state = EJECT;
            EJECT: begin
                if (!card_in) next_state = IDLE;
            end
            CAPTURE: begin
                if (!card_in) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer           <= '0;
            tries           <= CW'(MAX_TRIES);
            wbal            <= '0;
            disp_balance    <= '0;
            update_balance  <= '0;
            dispense_amount <= '0;
            dispense_valid  <= 1'b0;
            pin_error       <= 1'b0;
            insufficient    <= 1'b0;
        end else begin
            pin_error      <= pin_bad;
            insufficient   <= op_reject;
            dispense_valid <= op_wd;
            if (next_state != state || clear_timer)
                timer <= '0;
            else if ((state == PIN_WAIT || state == MENU) && !timeout)
                timer <= timer + 1'b1;
            if (load_ok) begin
                wbal  <= balance;
                tries <= CW'(MAX_TRIES);
            end
            if (pin_bad) tries <= tries - 1'b1;
            if (op_show) disp_balance <= wbal;
            if (op_wd) begin
                wbal            <= wbal - amount;
                disp_balance    <= wbal - amount;
                dispense_amount <= amount;
            end
            if (op_dep) begin
                wbal         <= dep_sum[BLNC_WIDTH-1:0];
                disp_balance <= dep_sum[BLNC_WIDTH-1:0];
            end
            // wbal is never modified on the cycle that enters COMMIT.
            if (state == MENU && next_state == COMMIT) update_balance <= wbal;
        end
    end

    assign operation_done = (state == COMMIT);
    assign card_out       = (state == COMMIT) || (state == EJECT);
    assign card_captured  = (state == CAPTURE);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: directed sessions push expected
// pulse events; a forked monitor pops and compares them at each negedge.
module tb_atm_session_ctrl;

    localparam int TMO = 1000;
    localparam int K_DISP   = 0;
    localparam int K_PINERR = 1;
    localparam int K_INSUF  = 2;
    localparam int K_COMMIT = 3;

    logic        clk = 1'b0;
    logic        reset, card_in, pass_flag, pin_valid, op_valid;
    logic [15:0] password, pin_entry;
    logic [19:0] balance, amount;
    logic [1:0]  op_sel;
    logic        operation_done, card_out, dispense_valid, pin_error;
    logic        insufficient, card_captured, busy;
    logic [19:0] update_balance, disp_balance, dispense_amount;

    typedef struct {
        int kind;
        int val;
        int disp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    atm_session_ctrl #(
        .PASS_WIDTH(16), .BLNC_WIDTH(20), .MAX_TRIES(3), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .card_in(card_in), .pass_flag(pass_flag),
        .password(password), .balance(balance), .pin_valid(pin_valid),
        .pin_entry(pin_entry), .op_valid(op_valid), .op_sel(op_sel),
        .amount(amount), .operation_done(operation_done), .card_out(card_out),
        .update_balance(update_balance), .disp_balance(disp_balance),
        .dispense_valid(dispense_valid), .dispense_amount(dispense_amount),
        .pin_error(pin_error), .insufficient(insufficient),
        .card_captured(card_captured), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic pushExp(input int kind, input int val, input int disp);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.disp = disp;
        sbq.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit is_pin, input logic [15:0] pin,
                                 input logic [1:0] op, input logic [19:0] amt);
        if (is_pin) begin
            pin_valid = 1'b1;
            pin_entry = pin;
        end else begin
            op_valid = 1'b1;
            op_sel   = op;
            amount   = amt;
        end
        cyc(1);
        pin_valid = 1'b0;
        op_valid  = 1'b0;
    endtask

    task automatic startSession(input bit pf, input logic [19:0] bal);
        password  = 16'h3506;
        balance   = bal;
        pass_flag = pf;
        card_in   = 1'b1;
        cyc(2);
    endtask

    task automatic monitorEvent(input int kind);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_unexpected: got event kind %0d expected none", kind);
        end else begin
            e = sbq.pop_front();
            checkOutput("sb_kind", kind, e.kind);
            case (kind)
                K_DISP: begin
                    checkOutput("sb_dispense_amount", dispense_amount, e.val);
                    checkOutput("sb_disp_after_dispense", disp_balance, e.disp);
                end
                K_INSUF: checkOutput("sb_disp_after_reject", disp_balance, e.disp);
                K_COMMIT: begin
                    checkOutput("sb_update_balance", update_balance, e.val);
                    checkOutput("sb_commit_card_out", card_out, 1);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        int  waited;
        bit  seen;

        reset = 1'b1; card_in = 1'b0; pass_flag = 1'b0; pin_valid = 1'b0;
        op_valid = 1'b0; password = '0; pin_entry = '0; balance = '0;
        amount = '0; op_sel = '0;

        fork
            forever begin
                @(negedge clk);
                if (dispense_valid === 1'b1) monitorEvent(K_DISP);
                if (pin_error === 1'b1)      monitorEvent(K_PINERR);
                if (insufficient === 1'b1)   monitorEvent(K_INSUF);
                if (operation_done === 1'b1) monitorEvent(K_COMMIT);
            end
        join_none

        cyc(2);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_card_out", card_out, 0);
        checkOutput("rst_operation_done", operation_done, 0);
        checkOutput("rst_card_captured", card_captured, 0);
        checkOutput("rst_dispense_valid", dispense_valid, 0);
        checkOutput("rst_disp_balance", disp_balance, 0);
        checkOutput("rst_update_balance", update_balance, 0);
        reset = 1'b0;
        cyc(1);

        $display("[TB] valid card, withdraw 20000, exit");
        startSession(1'b1, 20'd50000);
        checkOutput("s1_busy", busy, 1);
        checkOutput("s1_card_out_pinwait", card_out, 0);
        applyStimulus(1'b1, 16'h3506, 2'b00, '0);
        pushExp(K_DISP, 20000, 30000);
        applyStimulus(1'b0, '0, 2'b01, 20'd20000);
        pushExp(K_COMMIT, 30000, 0);
        applyStimulus(1'b0, '0, 2'b11, '0);
        cyc(1);
        checkOutput("s1_eject_card_out", card_out, 1);
        checkOutput("s1_eject_operation_done", operation_done, 0);
        card_in = 1'b0;
        cyc(1);
        checkOutput("s1_idle_busy", busy, 0);
        checkOutput("s1_idle_card_out", card_out, 0);
        checkOutput("s1_update_hold", update_balance, 30000);

        $display("[TB] three wrong PINs capture the card");
        startSession(1'b1, 20'd50000);
        for (int i = 0; i < 3; i++) begin
            pushExp(K_PINERR, 0, 0);
            applyStimulus(1'b1, 16'h1111, 2'b00, '0);
            checkOutput("s2_card_out_during_pin", card_out, 0);
        end
        checkOutput("s2_captured", card_captured, 1);
        cyc(3);
        checkOutput("s2_captured_hold", card_captured, 1);
        checkOutput("s2_card_out_captured", card_out, 0);
        card_in = 1'b0;
        cyc(1);
        checkOutput("s2_release_captured", card_captured, 0);
        checkOutput("s2_release_busy", busy, 0);

        $display("[TB] reject paths and deposit boundary");
        startSession(1'b1, 20'd50000);
        applyStimulus(1'b1, 16'h3506, 2'b00, '0);
        applyStimulus(1'b0, '0, 2'b00, '0);
        checkOutput("s3_show_balance", disp_balance, 50000);
        pushExp(K_INSUF, 0, 50000);
        applyStimulus(1'b0, '0, 2'b01, 20'd60000);
        pushExp(K_INSUF, 0, 50000);
        applyStimulus(1'b0, '0, 2'b10, 20'd998576);
        applyStimulus(1'b0, '0, 2'b10, 20'd100);
        checkOutput("s3_deposit_100", disp_balance, 50100);
        applyStimulus(1'b0, '0, 2'b10, 20'd998475);
        checkOutput("s3_deposit_to_max", disp_balance, 1048575);
        pin_valid = 1'b1; pin_entry = 16'h1111;
        op_valid  = 1'b1; op_sel = 2'b00; amount = '0;
        cyc(1);
        pin_valid = 1'b0; op_valid = 1'b0;
        checkOutput("s3_dual_strobe_disp", disp_balance, 1048575);
        pushExp(K_DISP, 1048575, 0);
        applyStimulus(1'b0, '0, 2'b01, 20'd1048575);
        pushExp(K_DISP, 0, 0);
        applyStimulus(1'b0, '0, 2'b01, 20'd0);
        pushExp(K_COMMIT, 0, 0);
        applyStimulus(1'b0, '0, 2'b11, '0);
        cyc(1);
        card_in = 1'b0;
        cyc(1);

        $display("[TB] invalid card goes straight to eject");
        startSession(1'b0, 20'd50000);
        checkOutput("s4_card_out", card_out, 1);
        checkOutput("s4_operation_done", operation_done, 0);
        applyStimulus(1'b1, 16'h1111, 2'b00, '0);
        checkOutput("s4_card_out_hold", card_out, 1);
        card_in = 1'b0;
        cyc(1);
        checkOutput("s4_idle_busy", busy, 0);

        $display("[TB] menu timeout commits");
        startSession(1'b1, 20'd50000);
        applyStimulus(1'b1, 16'h3506, 2'b00, '0);
        pushExp(K_DISP, 1000, 49000);
        pushExp(K_COMMIT, 49000, 0);
        applyStimulus(1'b0, '0, 2'b01, 20'd1000);
        seen = 1'b0; waited = 0;
        for (int i = 1; i <= TMO + 50; i++) begin
            cyc(1);
            if (operation_done === 1'b1) begin
                seen = 1'b1; waited = i;
                break;
            end
        end
        checkOutput("s5_menu_timeout_seen", seen, 1);
        if (seen) checkOutput("s5_menu_timeout_window", (waited >= TMO - 1 && waited <= TMO + 2), 1);
        cyc(1);
        checkOutput("s5_eject_card_out", card_out, 1);
        checkOutput("s5_eject_operation_done", operation_done, 0);
        card_in = 1'b0;
        cyc(1);

        $display("[TB] pin wait timeout ejects without commit");
        startSession(1'b1, 20'd50000);
        seen = 1'b0; waited = 0;
        for (int i = 1; i <= TMO + 50; i++) begin
            cyc(1);
            if (card_out === 1'b1) begin
                seen = 1'b1; waited = i;
                break;
            end
        end
        checkOutput("s6_pin_timeout_seen", seen, 1);
        if (seen) checkOutput("s6_pin_timeout_window", (waited >= TMO - 1 && waited <= TMO + 2), 1);
        checkOutput("s6_no_commit", operation_done, 0);
        card_in = 1'b0;
        cyc(1);

        $display("[TB] reset in menu aborts the session");
        startSession(1'b1, 20'd50000);
        applyStimulus(1'b1, 16'h3506, 2'b00, '0);
        pushExp(K_DISP, 1000, 49000);
        applyStimulus(1'b0, '0, 2'b01, 20'd1000);
        reset = 1'b1;
        cyc(1);
        checkOutput("s7_busy", busy, 0);
        checkOutput("s7_card_out", card_out, 0);
        checkOutput("s7_operation_done", operation_done, 0);
        checkOutput("s7_disp_balance", disp_balance, 0);
        checkOutput("s7_dispense_amount", dispense_amount, 0);
        card_in = 1'b0;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        checkOutput("s7_idle_after_reset", busy, 0);

        $display("[TB] card removal in menu commits");
        startSession(1'b1, 20'd50000);
        applyStimulus(1'b1, 16'h3506, 2'b00, '0);
        pushExp(K_DISP, 500, 49500);
        applyStimulus(1'b0, '0, 2'b01, 20'd500);
        pushExp(K_COMMIT, 49500, 0);
        card_in = 1'b0;
        op_valid = 1'b1; op_sel = 2'b01; amount = 20'd100;
        cyc(1);
        op_valid = 1'b0;
        checkOutput("s8_commit", operation_done, 1);
        cyc(1);
        checkOutput("s8_eject_card_out", card_out, 1);
        cyc(1);
        checkOutput("s8_idle_busy", busy, 0);

        cyc(3);
        checkOutput("sb_drain", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
